// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller:
// state encoding, default frame width and the one-bit shift helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int SIPO_WIDTH = 8;

  // Shifts one bit into a w-bit word carried in 32 bits; upper bits stay zero.
  function automatic logic [31:0] sipo_shift_word(input logic [31:0] word,
                                                  input logic        b,
                                                  input int          w,
                                                  input logic        msb_first);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (msb_first) begin
      res = ((word << 1) | {31'd0, b}) & mask;
    end else begin
      res = ((word & mask) >> 1) | ({31'd0, b} << (w - 1));
    end
    return res;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit shift register; clr has priority over en and
// MSB_FIRST selects the direction new bits enter from.
module sipo_shift
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next shift-register contents
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = WIDTH'(sipo_shift_word(32'(q_q), serial_in, WIDTH, MSB_FIRST != 0));
    end else begin
      q_d = q_q;
    end
  end

  // Shift-register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH serial bits after a start strobe, presents
// the word with a valid/ready handshake and flags starts that arrive too early.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ovr_set;
  logic             sh_clr;
  logic             sh_en;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] word_nxt;

  sipo_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sh_clr),
    .en        (sh_en),
    .serial_in (serial_in),
    .q         (sh_q)
  );

  // The final bit is folded in here so data_out loads on the same edge it is sampled.
  assign word_nxt = WIDTH'(sipo_shift_word(32'(sh_q), serial_in, WIDTH, MSB_FIRST != 0));

  // Next-state, counter, handshake and overrun-set decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        ovr_set = start;
        if (bit_en) begin
          sh_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            dout_d  = word_nxt;
            valid_d = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HOLD: begin
        if (data_ready) begin
          valid_d = 1'b0;
          // Start alongside the transfer opens the next frame with no idle cycle.
          if (start) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sh_clr  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ovr_set = start;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        sh_clr  = 1'b1;
      end
    endcase
  end

  // Sticky overrun: a set in the same cycle as a clear wins
  always_comb begin
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: MSB-first and LSB-first instances
// driven in parallel, expected words computed by hand.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       bit_en;
  logic       serial_in;
  logic       data_ready;
  logic       overrun_clr;
  logic [7:0] dout;
  logic       valid;
  logic       busy;
  logic       ovr;
  logic [7:0] lsb_dout;
  logic       lsb_valid;
  logic       lsb_busy;
  logic       lsb_ovr;

  int n_chk  = 0;
  int n_fail = 0;

  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bit_en      (bit_en),
    .serial_in   (serial_in),
    .data_out    (dout),
    .data_valid  (valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (ovr),
    .overrun_clr (overrun_clr)
  );

  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bit_en      (bit_en),
    .serial_in   (serial_in),
    .data_out    (lsb_dout),
    .data_valid  (lsb_valid),
    .data_ready  (data_ready),
    .busy        (lsb_busy),
    .overrun     (lsb_ovr),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Shifts nbits of pat (MSB of pat first), gap cycles per bit, optional start on bit index start_at.
  task automatic shift_bits(input logic [7:0] pat, input int nbits, input int gap, input int start_at);
    for (int i = 0; i < nbits; i++) begin
      bit_en    = 1'b1;
      serial_in = pat[7-i];
      start     = (i == start_at);
      tick();
      bit_en = 1'b0;
      start  = 1'b0;
      if (i == start_at) check_val("ovr_set_in_shift", {31'd0, ovr}, 32'd1);
      check_val("busy_shift", {31'd0, busy}, 32'd1);
      if (i < 7) check_val("no_early_valid", {31'd0, valid}, 32'd0);
      if (i < nbits - 1) begin
        for (int g = 1; g < gap; g++) begin
          tick();
          check_val("busy_gap", {31'd0, busy}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] pat2;
    int         cyc;
    rst_n       = 1'b0;
    start       = 1'b0;
    bit_en      = 1'b0;
    serial_in   = 1'b0;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    pat2        = 8'h5A;
    #12;
    check_val("rst_dout", {24'd0, dout}, 32'h00);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ovr", {31'd0, ovr}, 32'd0);
    rst_n = 1'b1;

    // Basic frame, both bit orders, ready already high
    data_ready = 1'b1;
    start_frame();
    shift_bits(8'hB2, 8, 1, -1);
    check_val("b2_valid", {31'd0, valid}, 32'd1);
    check_val("b2_dout", {24'd0, dout}, 32'hB2);
    check_val("lsb_valid", {31'd0, lsb_valid}, 32'd1);
    check_val("lsb_dout_4d", {24'd0, lsb_dout}, 32'h4D);
    tick();
    check_val("b2_valid_one_cycle", {31'd0, valid}, 32'd0);
    check_val("b2_idle_busy", {31'd0, busy}, 32'd0);
    check_val("b2_dout_retained", {24'd0, dout}, 32'hB2);

    // Gapped bits, downstream stalls five cycles; start+clr during stall sets overrun
    data_ready = 1'b0;
    start_frame();
    shift_bits(8'hB2, 8, 3, -1);
    for (int k = 0; k < 5; k++) begin
      check_val("hold_valid", {31'd0, valid}, 32'd1);
      check_val("hold_dout", {24'd0, dout}, 32'hB2);
      check_val("hold_busy", {31'd0, busy}, 32'd1);
      if (k == 2) begin
        start       = 1'b1;
        overrun_clr = 1'b1;
      end
      tick();
      start       = 1'b0;
      overrun_clr = 1'b0;
      if (k == 2) check_val("ovr_set_wins", {31'd0, ovr}, 32'd1);
    end
    check_val("hold_valid_6", {31'd0, valid}, 32'd1);
    check_val("hold_dout_6", {24'd0, dout}, 32'hB2);
    data_ready = 1'b1;
    tick();
    check_val("stall_release_valid", {31'd0, valid}, 32'd0);
    check_val("stall_release_idle", {31'd0, busy}, 32'd0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check_val("ovr_cleared_1", {31'd0, ovr}, 32'd0);

    // Start in the middle of a frame: overrun, frame still completes
    start_frame();
    shift_bits(8'hC5, 8, 1, 3);
    check_val("c5_valid", {31'd0, valid}, 32'd1);
    check_val("c5_dout", {24'd0, dout}, 32'hC5);
    check_val("c5_lsb_dout", {24'd0, lsb_dout}, 32'hA3);
    tick();
    check_val("c5_done", {31'd0, valid}, 32'd0);
    check_val("ovr_sticky", {31'd0, ovr}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check_val("ovr_cleared_2", {31'd0, ovr}, 32'd0);

    // Back-to-back frames: start with the transfer of the first word
    data_ready = 1'b0;
    start_frame();
    shift_bits(8'h3C, 8, 1, -1);
    check_val("b2b_first_valid", {31'd0, valid}, 32'd1);
    check_val("b2b_first_dout", {24'd0, dout}, 32'h3C);
    data_ready = 1'b1;
    start      = 1'b1;
    bit_en     = 1'b1;
    tick();
    start = 1'b0;
    check_val("b2b_xfer_valid", {31'd0, valid}, 32'd0);
    check_val("b2b_xfer_busy", {31'd0, busy}, 32'd1);
    check_val("b2b_dout_kept", {24'd0, dout}, 32'h3C);
    cyc = 1;
    while (!valid && cyc < 20) begin
      serial_in = (cyc <= 8) ? pat2[8-cyc] : 1'b0;
      tick();
      cyc++;
    end
    bit_en = 1'b0;
    check_val("b2b_latency", cyc, 32'd9);
    check_val("b2b_second_dout", {24'd0, dout}, 32'h5A);
    check_val("b2b_no_ovr", {31'd0, ovr}, 32'd0);
    tick();
    check_val("b2b_done_valid", {31'd0, valid}, 32'd0);
    check_val("b2b_done_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset after five bits
    start_frame();
    shift_bits(8'hA0, 5, 1, -1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, valid}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_dout", {24'd0, dout}, 32'h00);
    check_val("arst_lsb_busy", {31'd0, lsb_busy}, 32'd0);
    check_val("arst_lsb_ovr", {31'd0, lsb_ovr}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_val("post_rst_no_valid", {31'd0, valid}, 32'd0);
    check_val("post_rst_idle", {31'd0, busy}, 32'd0);
    start_frame();
    shift_bits(8'hFF, 8, 1, -1);
    check_val("ff_valid", {31'd0, valid}, 32'd1);
    check_val("ff_dout", {24'd0, dout}, 32'hFF);
    check_val("ff_lsb_dout", {24'd0, lsb_dout}, 32'hFF);
    tick();
    check_val("ff_done", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit lands in data_out[WIDTH-1], 0 = first bit lands in data_out[0].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  one-cycle frame-start strobe.
REQ-006 bit_en  input  1  bit strobe; serial_in is sampled only on cycles where bit_en=1 in SHIFT.
REQ-007 serial_in  input  1  serial data bit.
REQ-008 data_out  output  WIDTH  assembled parallel word; stable while data_valid=1.
REQ-009 data_valid  output  1  word available.
REQ-010 data_ready  input  1  downstream accept; transfer occurs when data_valid=1 and data_ready=1.
REQ-011 busy  output  1  high in SHIFT and HOLD.
REQ-012 overrun  output  1  sticky error flag.
REQ-013 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-014 FSM states: IDLE, SHIFT, HOLD.
REQ-015 IDLE: start=1 -> SHIFT; bit counter cleared to 0; shift register cleared to 0.
REQ-016 SHIFT: each bit_en=1 cycle shifts serial_in in (direction per MSB_FIRST) and increments counter; bit_en=0 cycles hold all state.
REQ-017 SHIFT: on bit_en=1 with counter=WIDTH-1, final bit is shifted in, word is copied to data_out, data_valid rises next edge, state -> HOLD.
REQ-018 Latency: data_valid=1 in the cycle immediately after the clock edge that samples the WIDTH-th bit.
REQ-019 HOLD: data_out and data_valid held until data_ready=1; on transfer data_valid clears next edge and state -> IDLE.
REQ-020 HOLD with data_ready=1 and start=1 in the same cycle: transfer completes and state -> SHIFT directly (back-to-back frames, no lost cycle); overrun not set.
REQ-021 start=1 in SHIFT, or in HOLD with data_ready=0: ignored for framing, overrun set to 1 next edge.
REQ-022 overrun_clr=1 clears overrun next edge; if a set condition coincides, set wins.
REQ-023 data_out changes only on the REQ-017 load; retains last word in IDLE.
REQ-024 Counter width is clog2(WIDTH); counter never exceeds WIDTH-1; no wrap beyond frame end.
REQ-025 busy = (state != IDLE), combinational from state.

Reset
REQ-026 rst_n=0 asynchronously forces state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, overrun=0.
REQ-027 Reset mid-SHIFT or mid-HOLD discards partial/pending word; no data_valid after release until a new full frame.
REQ-028 Reset deassertion takes effect on the next posedge clk; the first start is accepted on that edge.

Structure
REQ-029 Shared package sipo_pkg holds the state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) and the default WIDTH constant.
REQ-030 One sub-module sipo_shift: WIDTH-bit shift register with clk, rst_n, clr, en, serial_in, MSB_FIRST parameter, parallel q output; FSM, counter, handshake and flags stay in sipo_frame_ctrl.
REQ-031 No latches; unused state encoding 2'd3 returns to IDLE.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, start then 8 bit_en cycles with bits 1,0,1,1,0,0,1,0, data_ready=1 -> data_out=8'hB2, data_valid high exactly 1 cycle, one cycle after the 8th bit.
REQ-033 Same bits, MSB_FIRST=0 -> data_out=8'h4D.
REQ-034 bit_en gapped (1 of every 3 cycles), data_ready=0 for 5 cycles after valid -> data_out=8'hB2 held stable 6 cycles, busy=1 throughout, then IDLE.
REQ-035 start pulsed at bit 4 of a frame -> overrun=1 next cycle, frame completes normally with correct word; overrun_clr pulse -> overrun=0.
REQ-036 HOLD with data_ready=1 and start=1 same cycle, second frame 8'h5A -> both words delivered, second data_valid exactly 9 cycles after the first transfer when bit_en=1 continuously, overrun=0.
REQ-037 rst_n=0 asynchronously after 5 bits -> data_valid=0, busy=0, data_out=0 immediately; next full frame 8'hFF delivered correctly.
